sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO, the next-generation successor of our basic extended-pointer synchronous FIFO. Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky-free overflow/underflow error pulses, a first-word-fall-through (FWFT) read mode, and accepts a write while full when a read retires in the same cycle. Used as the standard buffering element between single-clock-domain producers and consumers.

---
 rtl/sync_fifo_flags_if.sv | 29 ++
 rtl/sync_fifo_flags.sv | 77 +++++++
 tb/tb_sync_fifo_flags.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle for sync_fifo_flags: producer/consumer side is master, FIFO is slave.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16
);
  localparam int AW = $clog2(DATA_DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [AW:0]           data_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, empty, full, almost_full, almost_empty, data_count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, empty, full, almost_full, almost_empty, data_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with extended pointers, programmable almost flags, occupancy,
// overflow/underflow pulses and optional first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int AF_LEVEL   = DATA_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_flags_if.slave  fifo_if
);
  localparam int AW = $clog2(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  rd_ok, wr_ok, empty, full;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DATA_DEPTH));

  // A read retiring in the same cycle frees a slot, so a write at full still lands.
  assign rd_ok = fifo_if.rd_en & ~empty;
  assign wr_ok = fifo_if.wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    ovf_d = fifo_if.wr_en & ~wr_ok;
    udf_d = fifo_if.rd_en & ~rd_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= fifo_if.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign fifo_if.data_out = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      assign dout_d = rd_ok ? mem[rd_ptr_q[AW-1:0]] : dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end
      assign fifo_if.data_out = dout_q;
    end
  endgenerate

  assign fifo_if.empty        = empty;
  assign fifo_if.full         = full;
  assign fifo_if.almost_full  = (count >= (AW+1)'(AF_LEVEL));
  assign fifo_if.almost_empty = (count <= (AW+1)'(AE_LEVEL));
  assign fifo_if.data_count   = count;
  assign fifo_if.overflow     = ovf_q;
  assign fifo_if.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a registered-read and an FWFT instance with identical stimulus and checks
// both every cycle against a queue model of FIFO behaviour.
module tb_sync_fifo_flags;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AFL = 14;
  localparam int AEL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] din = '0;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) if0 ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) if1 ();

  assign if0.wr_en = wr_en;  assign if0.data_in = din;  assign if0.rd_en = rd_en;
  assign if1.wr_en = wr_en;  assign if1.data_in = din;  assign if1.rd_en = rd_en;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0))
    u_std (.clk(clk), .rst_n(rst_n), .fifo_if(if0));
  sync_fifo_flags #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1))
    u_fwft (.clk(clk), .rst_n(rst_n), .fifo_if(if1));

  int total = 0;
  int bad = 0;

  // Behavioural model
  logic [DW-1:0] q[$];
  logic [DW-1:0] e_dout0 = '0;
  logic e_ovf = 1'b0, e_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    e_dout0 = '0;
    e_ovf = 1'b0;
    e_udf = 1'b0;
  endtask

  task automatic model_edge(input bit w, input logic [DW-1:0] d, input bit r);
    bit rok, wok;
    rok = r && (q.size() > 0);
    wok = w && ((q.size() < DEPTH) || rok);
    if (rok) e_dout0 = q.pop_front();
    if (wok) q.push_back(d);
    e_ovf = w && !wok;
    e_udf = r && !rok;
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("count0", 32'(if0.data_count), n);
    chk("count1", 32'(if1.data_count), n);
    chk("empty0", 32'(if0.empty), (n == 0));
    chk("empty1", 32'(if1.empty), (n == 0));
    chk("full0", 32'(if0.full), (n == DEPTH));
    chk("full1", 32'(if1.full), (n == DEPTH));
    chk("afull0", 32'(if0.almost_full), (n >= AFL));
    chk("afull1", 32'(if1.almost_full), (n >= AFL));
    chk("aempty0", 32'(if0.almost_empty), (n <= AEL));
    chk("aempty1", 32'(if1.almost_empty), (n <= AEL));
    chk("ovf0", 32'(if0.overflow), 32'(e_ovf));
    chk("ovf1", 32'(if1.overflow), 32'(e_ovf));
    chk("udf0", 32'(if0.underflow), 32'(e_udf));
    chk("udf1", 32'(if1.underflow), 32'(e_udf));
    chk("dout_std", 32'(if0.data_out), 32'(e_dout0));
    chk("dout_fwft", 32'(if1.data_out), (n > 0) ? 32'(q[0]) : 32'd0);
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    wr_en = w; din = d; rd_en = r;
    @(posedge clk);
    if (rst_n) model_edge(w, d, r);
    #1;
    compare_all();
  endtask

  initial begin
    // Reset state
    #22;
    model_reset();
    compare_all();
    chk("lit_rst_empty", 32'(if0.empty), 1);
    chk("lit_rst_aempty", 32'(if0.almost_empty), 1);
    chk("lit_rst_dout", 32'(if0.data_out), 0);
    rst_n = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 12) chk("lit_af_13", 32'(if0.almost_full), 0);
      if (i == 13) chk("lit_af_14", 32'(if0.almost_full), 1);
    end
    chk("lit_full", 32'(if0.full), 1);
    chk("lit_cnt16", 32'(if0.data_count), 16);
    step(1'b1, 8'hEE, 1'b0);
    chk("lit_ovf", 32'(if0.overflow), 1);
    step(1'b0, 8'h00, 1'b0);
    chk("lit_ovf_clr", 32'(if0.overflow), 0);
    chk("lit_fwft_head", 32'(if1.data_out), 8'h00);

    // Drain in order, then one extra read
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("lit_drain", 32'(if0.data_out), i);
    end
    chk("lit_empty", 32'(if0.empty), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("lit_udf", 32'(if0.underflow), 1);
    chk("lit_hold", 32'(if0.data_out), 8'h0F);

    // Full with simultaneous read/write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b1, 8'hA5, 1'b1);
    chk("lit_fullrw_dout", 32'(if0.data_out), 8'h10);
    chk("lit_fullrw_ovf", 32'(if0.overflow), 0);
    chk("lit_fullrw_cnt", 32'(if0.data_count), 16);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    chk("lit_a5_last", 32'(if0.data_out), 8'hA5);

    // Empty with simultaneous read/write
    step(1'b1, 8'h3C, 1'b1);
    chk("lit_emptyrw_udf", 32'(if0.underflow), 1);
    chk("lit_emptyrw_cnt", 32'(if0.data_count), 1);
    chk("lit_emptyrw_fwft", 32'(if1.data_out), 8'h3C);
    step(1'b0, 8'h00, 1'b1);

    // Wrap with count held at 3
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h43 + i), 1'b1);
      chk("lit_wrap_ae", 32'(if0.almost_empty), 1);
      chk("lit_wrap_full", 32'(if0.full), 0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // Randomized phases alternating fill-biased and drain-biased
    for (int i = 0; i < 800; i++) begin
      int pw;
      pw = ((i / 100) % 2 == 0) ? 75 : 30;
      step(($urandom_range(0, 99) < pw), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < (100 - pw)));
    end

    // Asynchronous reset mid-burst at count 9
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    chk("lit_cnt9", 32'(if0.data_count), 9);
    wr_en = 1'b1; din = 8'h99;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("lit_arst_empty", 32'(if0.empty), 1);
    chk("lit_arst_cnt", 32'(if0.data_count), 0);
    chk("lit_arst_dout", 32'(if0.data_out), 0);
    @(posedge clk);
    #1;
    compare_all();
    wr_en = 1'b0;
    #3;
    rst_n = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    chk("lit_post_fwft", 32'(if1.data_out), 8'h77);
    step(1'b0, 8'h00, 1'b1);
    chk("lit_post_std", 32'(if0.data_out), 8'h77);
    chk("lit_post_empty", 32'(if0.empty), 1);
    step(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
